// File: rtl/propagate32_unit_pkg.sv
// -----------------------------------------------------------------------------
// propagate32_unit_pkg
//   Shared ALU constants for the carry-lookahead front end.
//   WIDTH : operand width
//   GRP   : bits per lookahead group
//   NG    : number of lookahead groups (WIDTH / GRP)
//   Also provides a bundle type for the registered outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package propagate32_unit_pkg;

  localparam int WIDTH = 32;
  localparam int GRP   = 4;
  localparam int NG    = WIDTH / GRP;

  // Everything the output register stage holds, kept together so the
  // capture and reset paths stay in lock-step.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
  } pg_bundle_t;

  // Zero value used by the reset path of the output registers.
  function automatic pg_bundle_t pg_bundle_zero();
    pg_bundle_t z;
    z.p  = '0;
    z.g  = '0;
    z.gp = '0;
    z.gg = '0;
    return z;
  endfunction

endpackage

// File: rtl/propagate32_unit_group4.sv
// -----------------------------------------------------------------------------
// propagate_group4
//   One lookahead group slice: bit propagate/generate plus group
//   propagate/generate for the next lookahead level.
//   Ports:
//     a_i, b_i : GRP-bit operand slices
//     p_o      : bit propagate, a | b
//     g_o      : bit generate,  a & b
//     gp_o     : group propagate, AND of all p bits in the slice
//     gg_o     : group generate,  carry out of the slice assuming carry-in 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module propagate_group4
  import propagate32_unit_pkg::*;
#(
  parameter int GW = GRP
) (
  input  logic [GW-1:0] a_i,
  input  logic [GW-1:0] b_i,
  output logic [GW-1:0] p_o,
  output logic [GW-1:0] g_o,
  output logic          gp_o,
  output logic          gg_o
);

  logic [GW-1:0] p_bits;
  logic [GW-1:0] g_bits;

  assign p_bits = a_i | b_i;
  assign g_bits = a_i & b_i;

  assign p_o  = p_bits;
  assign g_o  = g_bits;
  assign gp_o = &p_bits;

  // Sum-of-products form: g[j] contributes when every p above it in the
  // slice lets it through. For GW=4 this expands to
  // g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
  always_comb begin
    logic term;
    gg_o = 1'b0;
    term = 1'b0;
    for (int j = 0; j < GW; j++) begin
      term = g_bits[j];
      for (int k = j + 1; k < GW; k++) begin
        term = term & p_bits[k];
      end
      gg_o = gg_o | term;
    end
  end

endmodule

// File: rtl/propagate32_unit.sv
// -----------------------------------------------------------------------------
// propagate32_unit
//   Carry-lookahead propagate/generate front end for the ALU adder.
//   Combinational outputs feed same-cycle adder logic; registered copies
//   (one cycle latency, no enable) feed pipelined consumers.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-high, clears registered outputs only
//     a, b   : operands
//     p, g   : bit propagate (a|b) / generate (a&b), combinational
//     gp, gg : group propagate / generate, combinational
//     p_r, g_r, gp_r, gg_r : registered copies of the above
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module propagate32_unit
  import propagate32_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic [NG-1:0]    gp,
  output logic [NG-1:0]    gg,
  output logic [WIDTH-1:0] p_r,
  output logic [WIDTH-1:0] g_r,
  output logic [NG-1:0]    gp_r,
  output logic [NG-1:0]    gg_r
);

  // WIDTH must be a multiple of GRP; NG is derived by integer division.

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      propagate_group4 #(
        .GW (GRP)
      ) u_grp (
        .a_i  (a[GRP*gi +: GRP]),
        .b_i  (b[GRP*gi +: GRP]),
        .p_o  (p[GRP*gi +: GRP]),
        .g_o  (g[GRP*gi +: GRP]),
        .gp_o (gp[gi]),
        .gg_o (gg[gi])
      );
    end
  endgenerate

  pg_bundle_t pg_d;
  pg_bundle_t pg_q;

  always_comb begin
    pg_d    = pg_bundle_zero();
    pg_d.p  = p;
    pg_d.g  = g;
    pg_d.gp = gp;
    pg_d.gg = gg;
  end

  // Reset wins over capture on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg_q <= pg_bundle_zero();
    end else begin
      pg_q <= pg_d;
    end
  end

  assign p_r  = pg_q.p;
  assign g_r  = pg_q.g;
  assign gp_r = pg_q.gp;
  assign gg_r = pg_q.gg;

endmodule

// File: tb/tb_propagate32_unit.sv
`timescale 1ns/1ps
module tb_propagate32_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] p;
  logic [31:0] g;
  logic [7:0]  gp;
  logic [7:0]  gg;
  logic [31:0] p_r;
  logic [31:0] g_r;
  logic [7:0]  gp_r;
  logic [7:0]  gg_r;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  gp;
    logic [7:0]  gg;
  } exp_t;

  exp_t sb[$];

  propagate32_unit dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .p     (p),
    .g     (g),
    .gp    (gp),
    .gg    (gg),
    .p_r   (p_r),
    .g_r   (g_r),
    .gp_r  (gp_r),
    .gg_r  (gg_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: group generate via the ripple recurrence c = g | p&c.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb);
    exp_t  r;
    logic  c;
    logic  all_p;
    r.p = ma | mb;
    r.g = ma & mb;
    for (int k = 0; k < 8; k++) begin
      c     = 1'b0;
      all_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        c     = r.g[4*k+i] | (r.p[4*k+i] & c);
        all_p = all_p & r.p[4*k+i];
      end
      r.gp[k] = all_p;
      r.gg[k] = c;
    end
    return r;
  endfunction

  // Drive one cycle of stimulus; check combinational outputs 0.35 after the
  // change, then check the registered outputs after the next rising edge.
  task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic rst);
    exp_t m;
    exp_t e;
    exp_t z;
    @(negedge clk);
    a     = na;
    b     = nb;
    reset = rst;
    #0.35;
    m = model(na, nb);
    check_val("p",  p,  m.p);
    check_val("g",  g,  m.g);
    check_val("gp", {24'h0, gp}, {24'h0, m.gp});
    check_val("gg", {24'h0, gg}, {24'h0, m.gg});
    z.p = '0; z.g = '0; z.gp = '0; z.gg = '0;
    sb.push_back(rst ? z : m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_val("p_r",  p_r,  e.p);
      check_val("g_r",  g_r,  e.g);
      check_val("gp_r", {24'h0, gp_r}, {24'h0, e.gp});
      check_val("gg_r", {24'h0, gg_r}, {24'h0, e.gg});
    end
    $display("txn a=%h b=%h rst=%0d p=%h g=%h gp=%h gg=%h p_r=%h gp_r=%h gg_r=%h",
             na, nb, rst, p, g, gp, gg, p_r, gp_r, gg_r);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    a        = '0;
    b        = '0;

    // Initial reset edge establishes a known register state.
    drive(32'h0000_0000, 32'h0000_0000, 1'b1);

    drive(32'hffff_ffff, 32'h0000_0000, 1'b0);
    check_val("p_r_lit", p_r, 32'hffff_ffff);
    check_val("gp_r_lit", {24'h0, gp_r}, 32'h0000_00ff);

    drive(32'ha47b_a47b, 32'h5c91_5c91, 1'b0);
    check_val("p_lit", p, 32'hfcfb_fcfb);
    check_val("g_lit", g, 32'h0411_0411);
    check_val("gp_lit", {24'h0, gp}, 32'h0000_00aa);

    drive(32'hbcda_bcda, 32'h7986_7986, 1'b0);
    check_val("p_lit2", p, 32'hfdde_fdde);
    drive(32'h9657_9657, 32'h3456_3456, 1'b0);
    check_val("p_lit3", p, 32'hb657_b657);

    // Reset held across two edges with all-ones operands.
    drive(32'hffff_ffff, 32'hffff_ffff, 1'b1);
    drive(32'hffff_ffff, 32'hffff_ffff, 1'b1);
    check_val("gg_lit_rst", {24'h0, gg}, 32'h0000_00ff);
    check_val("p_r_rst", p_r, 32'h0000_0000);
    drive(32'hffff_ffff, 32'hffff_ffff, 1'b0);
    check_val("gg_r_lit", {24'h0, gg_r}, 32'h0000_00ff);

    // Group generate chain through group 0.
    drive(32'h0000_000f, 32'h0000_0001, 1'b0);
    check_val("gp_chain", {24'h0, gp}, 32'h0000_0001);
    check_val("gg_chain", {24'h0, gg}, 32'h0000_0001);

    // Inputs changing every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(32'hffff_ffff, 32'h0000_0000, 1'b0);
      drive(32'ha47b_a47b, 32'h5c91_5c91, 1'b0);
    end

    // Reset for one edge mid-stream, then normal capture resumes.
    drive(32'h1234_5678, 32'h8765_4321, 1'b1);
    drive(32'h1234_5678, 32'h8765_4321, 1'b0);

    // Random operands.
    for (int i = 0; i < 24; i++) begin
      drive($urandom, $urandom, 1'b0);
    end

    check_val("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/propagate32_unit.md
Name: propagate32_unit

Overview:
- 32-bit carry-lookahead propagate/generate front end for the ALU adder.
- Produces bitwise propagate (a|b) and generate (a&b), plus 4-bit group propagate/generate for the next lookahead level.
- Combinational outputs feed same-cycle adder logic.
- Registered copies feed pipelined consumers.

Parameters:
- WIDTH, 32, operand width; must be a multiple of GRP.
- GRP, 4, bits per lookahead group; number of groups NG = WIDTH/GRP = 8.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset; affects registered outputs only
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- p  output  WIDTH  combinational bit propagate, a | b
- g  output  WIDTH  combinational bit generate, a & b
- gp  output  NG  combinational group propagate
- gg  output  NG  combinational group generate
- p_r  output  WIDTH  registered p
- g_r  output  WIDTH  registered g
- gp_r  output  NG  registered gp
- gg_r  output  NG  registered gg

Behaviour:
- p[i] = a[i] | b[i] for every bit; pure combinational, zero cycles latency.
- p must settle within 0.35 time units of an input change.
- p is independent of clk and reset.
- g[i] = a[i] & b[i]; combinational.
- Group k covers bits [GRP*k+GRP-1 : GRP*k].
- gp[k] = AND of p over group k.
- gg[k] = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0, with indices local to the group (generalised for any GRP).
- Registered outputs capture p, g, gp, gg on each rising clk edge; latency 1 cycle; no enable.
- reset high at a rising edge: p_r, g_r, gp_r, gg_r all become 0 on that edge.
- Reset overrides capture when both occur on the same edge.
- Reset mid-stream: the next edge after reset deasserts captures the current inputs normally.
- Power-up value of registered outputs is undefined until the first reset edge.
- No X-propagation masking: X on a or b propagates to the outputs.
- No arithmetic carry is produced; no overflow semantics in this block.

Decomposition:
- Shared ALU package holds WIDTH=32, GRP=4 and the derived NG constant.
- Natural sub-module: propagate_group4, one GRP-bit slice producing its p/g bits plus gp/gg. Instantiate it NG times via generate.
- Output registers sit in the top level.

Test Plan:
- a=ffffffff, b=00000000 -> p=ffffffff, g=00000000, gp=ff, gg=00; after one clk edge, p_r=ffffffff.
- a=a47ba47b, b=5c915c91 -> p=fcfbfcfb, g=04110411, gp=aa; p valid 0.35 after input change, before any clock edge.
- a=bcdabcda, b=79867986 -> p=fddefdde; a=96579657, b=34563456 -> p=b657b657.
  - Check p against a|b and g against a&b after each change.
- Hold reset=1 across two edges with a=ffffffff, b=ffffffff:
  - p=ffffffff and gg=ff combinationally.
  - p_r, g_r, gp_r, gg_r all 0.
  - Deassert reset: next edge gives p_r=ffffffff, gp_r=ff, gg_r=ff.
- Group generate chain, a=0000000f, b=00000001:
  - p=0000000f, g=00000001.
  - gp=01 (only group 0 has all four p bits set).
  - gg=01 (g0 propagated through p3,p2,p1).
- Change inputs every cycle (ffffffff/0, then a47ba47b/5c915c91): each registered output equals the previous cycle's combinational value.
